// File: rtl/br_pred_train_sched_pkg.sv
// Shared constants, types and counter helpers for the branch predictor
// training sequencer.
package br_pred_train_sched_pkg;

  localparam int CNTW     = 2;
  localparam int PRT_D    = 512;
  localparam int TBL_IDX  = $clog2(PRT_D);
  localparam int SIMBRCOM = 2;
  localparam int TRQ_D    = 8;
  localparam int DROPW    = 16;

  // Queue pointers carry one extra bit to tell full from empty.
  localparam int TRQ_AW   = $clog2(TRQ_D);
  localparam int TRQ_PW   = TRQ_AW + 1;

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_MIN = '0;
  // Weakly taken: the lowest value with the MSB set.
  localparam logic [CNTW-1:0] CNT_DEF = CNTW'((2**CNTW - 1) / 2 + 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [TBL_IDX-1:0] idx;
    logic               taken;
  } train_ev_t;

  // Saturating up/down step of a prediction counter.
  function automatic logic [CNTW-1:0] cnt_update(input logic [CNTW-1:0] cur,
                                                 input logic            taken);
    if (taken) return (cur == CNT_MAX) ? CNT_MAX : cur + CNTW'(1);
    else       return (cur == CNT_MIN) ? CNT_MIN : cur - CNTW'(1);
  endfunction

endpackage

// File: rtl/br_pred_train_sched_if.sv
// Commit-side training events plus the counter table port bundle.
interface br_pred_train_sched_if;
  import br_pred_train_sched_pkg::*;

  logic                        reinit_;
  logic [SIMBRCOM-1:0]         tr_;
  logic [SIMBRCOM*TBL_IDX-1:0] tr_idx;
  logic [SIMBRCOM-1:0]         tr_taken_;
  logic                        tbl_re_;
  logic [TBL_IDX-1:0]          tbl_ridx;
  logic [CNTW-1:0]             tbl_rd;
  logic                        tbl_we_;
  logic [TBL_IDX-1:0]          tbl_widx;
  logic [CNTW-1:0]             tbl_wd;
  logic                        init_done;
  logic                        busy;
  logic [DROPW-1:0]            drop_cnt;

  // Sequencer view.
  modport slave (
    input  reinit_, tr_, tr_idx, tr_taken_, tbl_rd,
    output tbl_re_, tbl_ridx, tbl_we_, tbl_widx, tbl_wd, init_done, busy, drop_cnt
  );

  // Environment view (commit stage plus table storage).
  modport master (
    output reinit_, tr_, tr_idx, tr_taken_, tbl_rd,
    input  tbl_re_, tbl_ridx, tbl_we_, tbl_widx, tbl_wd, init_done, busy, drop_cnt
  );
endinterface

// File: rtl/br_train_queue.sv
// Multi-write, single-read compacting training FIFO with a saturating
// count of events that did not fit.
module br_train_queue
  import br_pred_train_sched_pkg::*;
(
  input  logic                clk,
  input  logic                reset_,
  input  logic                i_clr,
  input  logic [SIMBRCOM-1:0] i_vld,
  input  train_ev_t           i_ev [SIMBRCOM],
  input  logic                i_pop,
  output logic                o_empty,
  output train_ev_t           o_head,
  output logic                o_busy,
  output logic [DROPW-1:0]    o_drop_cnt
);

  localparam int DSW = DROPW + 1;

  train_ev_t           r_mem [TRQ_D];
  logic [TRQ_PW-1:0]   r_wptr, r_rptr;
  logic                r_busy;
  logic [DROPW-1:0]    r_drop_cnt;

  logic [TRQ_PW-1:0]   w_free, w_n_acc, w_n_drop;
  logic [TRQ_PW-1:0]   w_wptr_nxt, w_rptr_nxt, w_occ_nxt;
  logic [SIMBRCOM-1:0] w_acc;
  logic [TRQ_AW-1:0]   w_slot [SIMBRCOM];
  logic                w_busy_nxt;
  logic [DSW-1:0]      w_drop_sum;

  // Free slots are taken before this cycle's pop.
  assign w_free = TRQ_PW'(TRQ_D) - (r_wptr - r_rptr);

  // Lane compaction: valid lanes take consecutive slots, lowest lane first.
  // NOTE: every variable is given a default before any branch so no latch is inferred.
  always_comb begin
    w_n_acc  = '0;
    w_n_drop = '0;
    w_acc    = '0;
    for (int l = 0; l < SIMBRCOM; l++) begin
      w_slot[l] = r_wptr[TRQ_AW-1:0] + w_n_acc[TRQ_AW-1:0];
      if (i_vld[l]) begin
        if (w_n_acc < w_free) begin
          w_acc[l] = 1'b1;
          w_n_acc  = w_n_acc + TRQ_PW'(1);
        end else begin
          w_n_drop = w_n_drop + TRQ_PW'(1);
        end
      end
    end
  end

  assign w_wptr_nxt = r_wptr + w_n_acc;
  assign w_rptr_nxt = r_rptr + TRQ_PW'(i_pop);
  assign w_occ_nxt  = w_wptr_nxt - w_rptr_nxt;
  assign w_busy_nxt = (TRQ_PW'(TRQ_D) - w_occ_nxt) < TRQ_PW'(SIMBRCOM);
  assign w_drop_sum = {1'b0, r_drop_cnt} + DSW'(w_n_drop);

  // Pointer, busy and drop-count state; a clear empties the queue but keeps the statistic.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_busy     <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
      r_busy     <= w_busy_nxt;
      r_drop_cnt <= w_drop_sum[DROPW] ? '1 : w_drop_sum[DROPW-1:0];
    end
  end

  // Entry storage writes for accepted lanes.
  // NOTE: the storage array has no reset; entries only matter between the pointers.
  always_ff @(posedge clk) begin
    for (int l = 0; l < SIMBRCOM; l++) begin
      if (w_acc[l] && !i_clr) r_mem[w_slot[l]] <= i_ev[l];
    end
  end

  assign o_empty    = (r_wptr == r_rptr);
  assign o_head     = r_mem[r_rptr[TRQ_AW-1:0]];
  assign o_busy     = r_busy;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/br_pred_train_sched.sv
// Prediction counter table sequencer: initialisation walk, then one
// read-modify-write saturating update per cycle from the training queue.
module br_pred_train_sched
  import br_pred_train_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_,
  br_pred_train_sched_if.slave bus
);

  state_e             r_state, w_state_nxt;
  logic [TBL_IDX-1:0] r_ptr, w_ptr_nxt;
  logic               r_iwr, w_iwr_nxt;
  logic [TBL_IDX-1:0] r_iidx;
  logic               r_init_done;

  logic               r_re_;
  logic [TBL_IDX-1:0] r_ridx;
  logic               r_s1_taken;
  logic               r_s2_vld;
  logic [TBL_IDX-1:0] r_s2_idx;
  logic               r_s2_taken;
  logic               r_fw_vld;
  logic [TBL_IDX-1:0] r_fw_idx;
  logic [CNTW-1:0]    r_fw_wd;

  logic                w_reinit, w_pop, w_clr, w_empty, w_busy;
  logic [SIMBRCOM-1:0] w_vld;
  train_ev_t           w_ev [SIMBRCOM];
  train_ev_t           w_head;
  logic [CNTW-1:0]     w_cur, w_new;
  logic [DROPW-1:0]    w_drop_cnt;

  assign w_reinit = ~bus.reinit_;
  assign w_vld    = ~bus.tr_;

  // Unpack the active-low lane bundle into queue entries.
  always_comb begin
    for (int l = 0; l < SIMBRCOM; l++) begin
      w_ev[l].idx   = bus.tr_idx[l*TBL_IDX +: TBL_IDX];
      w_ev[l].taken = ~bus.tr_taken_[l];
    end
  end

  br_train_queue u_queue (
    .clk        (clk),
    .reset_     (reset_),
    .i_clr      (w_clr),
    .i_vld      (w_vld),
    .i_ev       (w_ev),
    .i_pop      (w_pop),
    .o_empty    (w_empty),
    .o_head     (w_head),
    .o_busy     (w_busy),
    .o_drop_cnt (w_drop_cnt)
  );

  // Next state: walk the table in INIT, pop in RUN, flush in DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_iwr_nxt   = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        if (w_reinit) begin
          w_ptr_nxt = '0;
        end else begin
          w_iwr_nxt = 1'b1;
          w_ptr_nxt = r_ptr + TBL_IDX'(1);
          if (r_ptr == TBL_IDX'(PRT_D - 1)) begin
            w_ptr_nxt   = '0;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_reinit) w_state_nxt = ST_DRAIN;
        else          w_pop       = ~w_empty;
      end
      ST_DRAIN: begin
        // The only in-flight stage-2 write finishes this cycle.
        w_clr       = 1'b1;
        w_ptr_nxt   = '0;
        w_state_nxt = ST_INIT;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // State register plus the registered initialisation write.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= ST_INIT;
      r_ptr       <= '0;
      r_iwr       <= 1'b0;
      r_iidx      <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_iwr       <= w_iwr_nxt;
      r_iidx      <= r_ptr;
      r_init_done <= (w_state_nxt == ST_RUN);
    end
  end

  // Read-modify-write pipeline: stage 1 issues the read, stage 2 writes back.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_re_      <= 1'b1;
      r_ridx     <= '0;
      r_s1_taken <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_taken <= 1'b0;
      r_fw_vld   <= 1'b0;
      r_fw_idx   <= '0;
      r_fw_wd    <= '0;
    end else begin
      r_re_ <= ~w_pop;
      if (w_pop) begin
        r_ridx     <= w_head.idx;
        r_s1_taken <= w_head.taken;
      end
      r_s2_vld   <= ~r_re_;
      r_s2_idx   <= r_ridx;
      r_s2_taken <= r_s1_taken;
      r_fw_vld   <= r_s2_vld;
      r_fw_idx   <= r_s2_idx;
      r_fw_wd    <= w_new;
    end
  end

  // The table has not yet absorbed last cycle's write when it serves a
  // back-to-back read of the same entry, so take the value being written.
  assign w_cur = (r_fw_vld && (r_fw_idx == r_s2_idx)) ? r_fw_wd : bus.tbl_rd;
  assign w_new = cnt_update(w_cur, r_s2_taken);

  assign bus.tbl_re_   = r_re_;
  assign bus.tbl_ridx  = r_ridx;
  assign bus.tbl_we_   = ~(r_s2_vld | r_iwr);
  assign bus.tbl_widx  = r_s2_vld ? r_s2_idx : (r_iwr ? r_iidx  : '0);
  assign bus.tbl_wd    = r_s2_vld ? w_new    : (r_iwr ? CNT_DEF : '0);
  assign bus.init_done = r_init_done;
  assign bus.busy      = w_busy;
  assign bus.drop_cnt  = w_drop_cnt;

endmodule
